// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with load-use hazard stall, multi-cycle branch flush
// and saturating stall/flush event counters.
module if_id_stage #(
   parameter int          FLUSH_CYCLES = 1,
   parameter logic [15:0] NOP_INSTR    = 16'h0000,
   parameter int          CNT_W        = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [15:0]      pc4_in,
   input  logic [15:0]      instr_in,
   input  logic             flush,
   input  logic             idex_mem_read,
   input  logic [3:0]       idex_rt,
   output logic [15:0]      pc4_out,
   output logic [15:0]      instr_out,
   output logic             valid_out,
   output logic             pc_write,
   output logic             bubble,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);
   typedef enum logic {RUN, FLUSH} state_t;
   localparam logic [2:0]       FL_INIT = 3'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   state_t     state;
   logic [2:0] flush_left;
   logic       hazard;
   // Register 0 never carries a real dependency, so a load to r0 cannot stall.
   assign hazard = valid_out && idex_mem_read && (idex_rt != 4'd0) &&
                   ((instr_out[11:8] == idex_rt) || (instr_out[7:4] == idex_rt));
   assign pc_write = !hazard || flush;
   assign bubble   = hazard || flush;
   always_ff @(posedge clock) begin
      if (reset) begin
         pc4_out     <= '0;
         instr_out   <= NOP_INSTR;
         valid_out   <= 1'b0;
         stall_count <= '0;
         flush_count <= '0;
         state       <= RUN;
         flush_left  <= '0;
      end else if (flush) begin
         pc4_out     <= pc4_in;
         instr_out   <= NOP_INSTR;
         valid_out   <= 1'b0;
         flush_count <= (flush_count == CNT_MAX) ? flush_count : flush_count + CNT_W'(1);
         flush_left  <= FL_INIT;
         state       <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      end else if (state == FLUSH) begin
         // The edge that brings flush_left to zero is the last NOP edge of the burst.
         pc4_out    <= pc4_in;
         instr_out  <= NOP_INSTR;
         valid_out  <= 1'b0;
         flush_left <= (flush_left == 3'd0) ? 3'd0 : flush_left - 3'd1;
         state      <= (flush_left <= 3'd1) ? RUN : FLUSH;
      end else if (hazard) begin
         stall_count <= (stall_count == CNT_MAX) ? stall_count : stall_count + CNT_W'(1);
      end else begin
         pc4_out   <= pc4_in;
         instr_out <= instr_in;
         valid_out <= 1'b1;
      end
   end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: table-driven directed check of if_id_stage with FLUSH_CYCLES=3, CNT_W=2.
module tb_if_id_stage;
   localparam logic [15:0] NOP = 16'hF000;
   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] pc4_in, instr_in;
   logic        flush, idex_mem_read;
   logic [3:0]  idex_rt;
   logic [15:0] pc4_out, instr_out;
   logic        valid_out, pc_write, bubble;
   logic [1:0]  stall_count, flush_count;
   int          tests = 0;
   int          fails = 0;

   if_id_stage #(.FLUSH_CYCLES(3), .NOP_INSTR(NOP), .CNT_W(2)) dut (
      .clock(clock), .reset(reset), .pc4_in(pc4_in), .instr_in(instr_in),
      .flush(flush), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
      .pc4_out(pc4_out), .instr_out(instr_out), .valid_out(valid_out),
      .pc_write(pc_write), .bubble(bubble),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] instr;
      logic [15:0] pc4;
      logic        f;
      logic        mr;
      logic [3:0]  rt;
      logic        e_pw;
      logic        e_bub;
      logic [15:0] e_instr;
      logic [15:0] e_pc4;
      logic        e_valid;
      logic [1:0]  e_stall;
      logic [1:0]  e_flush;
   } vec_t;
   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_regs(input string tag, input logic [15:0] ei, input logic [15:0] ep,
                           input logic ev, input logic [1:0] es, input logic [1:0] ef);
      chk({tag, " instr_out"}, 32'(instr_out), 32'(ei));
      chk({tag, " pc4_out"}, 32'(pc4_out), 32'(ep));
      chk({tag, " valid_out"}, 32'(valid_out), 32'(ev));
      chk({tag, " stall_count"}, 32'(stall_count), 32'(es));
      chk({tag, " flush_count"}, 32'(flush_count), 32'(ef));
   endtask

   task automatic chk_comb(input string tag, input logic pw, input logic bub);
      chk({tag, " pc_write"}, 32'(pc_write), 32'(pw));
      chk({tag, " bubble"}, 32'(bubble), 32'(bub));
   endtask

   task automatic drive(input logic [15:0] i, input logic [15:0] p, input logic f,
                        input logic mr, input logic [3:0] rt);
      instr_in = i; pc4_in = p; flush = f; idex_mem_read = mr; idex_rt = rt;
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   initial begin
      //             instr     pc4      f     mr    rt    pw    bub   e_instr   e_pc4    v     st    fl
      vecs.push_back('{16'h1234, 16'h0002, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 16'h1234, 16'h0002, 1'b1, 2'd0, 2'd0});
      vecs.push_back('{16'h2350, 16'h0004, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 16'h2350, 16'h0004, 1'b1, 2'd0, 2'd0});
      vecs.push_back('{16'h4444, 16'h0006, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 16'h2350, 16'h0004, 1'b1, 2'd1, 2'd0});
      vecs.push_back('{16'h4444, 16'h0006, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 16'h4444, 16'h0006, 1'b1, 2'd1, 2'd0});
      vecs.push_back('{16'h5500, 16'h0008, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 16'h5500, 16'h0008, 1'b1, 2'd1, 2'd0});
      vecs.push_back('{16'h6666, 16'h000A, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 16'h6666, 16'h000A, 1'b1, 2'd1, 2'd0});
      vecs.push_back('{16'h7777, 16'h000C, 1'b0, 1'b1, 4'd6, 1'b0, 1'b1, 16'h6666, 16'h000A, 1'b1, 2'd2, 2'd0});
      vecs.push_back('{16'h7777, 16'h000C, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0, 16'h7777, 16'h000C, 1'b1, 2'd2, 2'd0});
      vecs.push_back('{16'h8888, 16'h000E, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, NOP,      16'h000E, 1'b0, 2'd2, 2'd1});
      vecs.push_back('{16'h9999, 16'h0010, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, NOP,      16'h0010, 1'b0, 2'd2, 2'd1});
      vecs.push_back('{16'hAAAA, 16'h0012, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, NOP,      16'h0012, 1'b0, 2'd2, 2'd1});
      vecs.push_back('{16'hBBBB, 16'h0014, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 16'hBBBB, 16'h0014, 1'b1, 2'd2, 2'd1});
      vecs.push_back('{16'hCCCC, 16'h0016, 1'b1, 1'b1, 4'hB, 1'b1, 1'b1, NOP,      16'h0016, 1'b0, 2'd2, 2'd2});
      vecs.push_back('{16'hDDDD, 16'h0018, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, NOP,      16'h0018, 1'b0, 2'd2, 2'd3});
      vecs.push_back('{16'hDDDD, 16'h001A, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, NOP,      16'h001A, 1'b0, 2'd2, 2'd3});
      vecs.push_back('{16'hDDDD, 16'h001C, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, NOP,      16'h001C, 1'b0, 2'd2, 2'd3});
      vecs.push_back('{16'hEEEE, 16'h001E, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 16'hEEEE, 16'h001E, 1'b1, 2'd2, 2'd3});
      vecs.push_back('{16'h1111, 16'h0020, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, NOP,      16'h0020, 1'b0, 2'd2, 2'd3});
      vecs.push_back('{16'h1111, 16'h0022, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, NOP,      16'h0022, 1'b0, 2'd2, 2'd3});
      vecs.push_back('{16'h1111, 16'h0024, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, NOP,      16'h0024, 1'b0, 2'd2, 2'd3});
      vecs.push_back('{16'h1210, 16'h0026, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 16'h1210, 16'h0026, 1'b1, 2'd2, 2'd3});

      reset = 1'b1;
      drive(16'h0, 16'h0, 1'b0, 1'b0, 4'd0);
      repeat (2) tick();
      chk_regs("reset", NOP, 16'h0, 1'b0, 2'd0, 2'd0);
      chk_comb("reset", 1'b1, 1'b0);
      reset = 1'b0;

      for (int k = 0; k < vecs.size(); k++) begin
         drive(vecs[k].instr, vecs[k].pc4, vecs[k].f, vecs[k].mr, vecs[k].rt);
         #1;
         chk_comb($sformatf("vec%0d", k), vecs[k].e_pw, vecs[k].e_bub);
         tick();
         chk_regs($sformatf("vec%0d", k), vecs[k].e_instr, vecs[k].e_pc4, vecs[k].e_valid,
                  vecs[k].e_stall, vecs[k].e_flush);
      end

      // Saturating stall counter: reset, load one instruction, hold a hazard for 6 cycles.
      reset = 1'b1;
      drive(16'h0, 16'h0, 1'b0, 1'b0, 4'd0);
      tick();
      reset = 1'b0;
      drive(16'h1210, 16'h0030, 1'b0, 1'b0, 4'd0);
      tick();
      chk_regs("first_after_reset", 16'h1210, 16'h0030, 1'b1, 2'd0, 2'd0);
      drive(16'h3333, 16'h0032, 1'b0, 1'b1, 4'd1);
      for (int c = 0; c < 6; c++) begin
         #1;
         chk_comb($sformatf("sat%0d", c), 1'b0, 1'b1);
         tick();
         chk_regs($sformatf("sat%0d", c), 16'h1210, 16'h0030, 1'b1, (c < 2) ? 2'(c + 1) : 2'd3, 2'd0);
      end

      // Reset while the hazard is still held returns to reset values on that edge.
      reset = 1'b1;
      tick();
      chk_regs("reset_mid_stall", NOP, 16'h0, 1'b0, 2'd0, 2'd0);
      chk_comb("reset_mid_stall", 1'b1, 1'b0);

      // Reset in the middle of a flush burst, then the first instruction loads at once.
      reset = 1'b0;
      drive(16'h4321, 16'h0040, 1'b1, 1'b0, 4'd0);
      tick();
      drive(16'h4321, 16'h0042, 1'b0, 1'b0, 4'd0);
      reset = 1'b1;
      tick();
      chk_regs("reset_mid_flush", NOP, 16'h0, 1'b0, 2'd0, 2'd0);
      reset = 1'b0;
      drive(16'h5678, 16'h0044, 1'b0, 1'b0, 4'd0);
      tick();
      chk_regs("load_after_flush_reset", 16'h5678, 16'h0044, 1'b1, 2'd0, 2'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline stage that sits directly downstream of instruction fetch and registers the fetched PC+4 and instruction for decode.
- Detects load-use hazards against the instruction currently in EX. On a hazard it holds IF/ID, freezes the PC and requests a bubble into ID/EX.
- On a taken branch it flushes IF/ID for a programmable number of cycles.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- FLUSH_CYCLES, 1, number of consecutive NOP cycles inserted per flush (legal 1..7).
- NOP_INSTR, 16'h0000, encoding loaded into instr_out when flushed or reset.
- CNT_W, 16, width of the stall and flush counters.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-high.
- pc4_in  input  16  PC+4 from fetch.
- instr_in  input  16  instruction from fetch.
- flush  input  1  taken branch (PCSrc); kills the wrong-path fetch.
- idex_mem_read  input  1  the instruction in ID/EX is a load.
- idex_rt  input  4  destination register of that load.
- pc4_out  output  16  registered PC+4 to decode.
- instr_out  output  16  registered instruction to decode.
- valid_out  output  1  instr_out is a real instruction.
- pc_write  output  1  PC enable; 0 freezes the PC.
- bubble  output  1  zero ID/EX control signals this cycle.
- stall_count  output  CNT_W  number of hazard-stall cycles.
- flush_count  output  CNT_W  number of flush events.

Behaviour:
- Instruction fields, fixed: opcode[15:12], rs[11:8], rt[7:4], rd[3:0]. Register 0 is hardwired zero.
- Hazard (combinational, from current registered state only): valid_out & idex_mem_read & (idex_rt != 0) & (instr_out[11:8] == idex_rt | instr_out[7:4] == idex_rt).
- Combinational outputs:
  - pc_write = !hazard | flush
  - bubble = hazard | flush
- Reset (synchronous, active-high, highest priority):
  - pc4_out = 0, instr_out = NOP_INSTR, valid_out = 0.
  - stall_count = 0, flush_count = 0, state = RUN, flush_left = 0.
- FSM states: RUN, FLUSH. Per-edge priority order: reset > flush > FLUSH state > hazard > normal load.
- flush asserted, in any state:
  - instr_out <= NOP_INSTR, valid_out <= 0, pc4_out <= pc4_in.
  - flush_count increments.
  - flush_left <= FLUSH_CYCLES-1.
  - Next state is FLUSH if FLUSH_CYCLES > 1, else RUN.
  - A flush arriving while in FLUSH restarts flush_left.
  - A flush in the same cycle as a hazard: flush wins, the hazard is not counted, and pc_write = 1.
- FLUSH state with no flush:
  - Load NOP_INSTR, valid_out <= 0, pc4_out <= pc4_in.
  - flush_left decrements; at 0 the state goes to RUN. The cycle in which flush_left is 0 still loads a NOP.
  - Hazards cannot occur here because valid_out = 0.
- RUN with hazard:
  - All IF/ID registers hold their values; pc_write = 0, bubble = 1.
  - stall_count increments.
  - The hazard clears the following cycle once the load leaves ID/EX, giving a 1-cycle stall for a single load.
- RUN with no hazard: pc4_out <= pc4_in, instr_out <= instr_in, valid_out <= 1.
- Latency: 1 cycle from instr_in to instr_out when not stalled.
- Counters saturate at 2^CNT_W-1; they never wrap.
- Reset asserted mid-stall or mid-flush returns everything to reset values on that edge. The first instruction is accepted on the first edge after reset deasserts.

Test Plan:
- Reset, then instr_in=16'h1234 and pc4_in=16'h0002 held for 1 cycle -> after 1 edge instr_out=16'h1234, pc4_out=16'h0002, valid_out=1, pc_write=1, bubble=0.
- instr_out=16'h2350 (rs=3), idex_mem_read=1, idex_rt=3 for 1 cycle -> pc_write=0 and bubble=1 that cycle, instr_out held, stall_count=1. Next cycle with idex_mem_read=0 loads the new instr_in.
- Same as above but idex_rt=0 -> no hazard, pc_write=1, stall_count=0.
- FLUSH_CYCLES=3, flush pulsed for 1 cycle -> instr_out=NOP_INSTR and valid_out=0 for exactly 3 edges, then a normal load; flush_count=1.
- Hazard and flush asserted together -> pc_write=1, bubble=1, instr_out=NOP_INSTR next edge, stall_count unchanged, flush_count+1.
- CNT_W=2, hazard held for 6 cycles -> stall_count reaches 3 and stays at 3. Reset asserted during this -> all outputs return to reset values on the next edge.
